witf_ptrk: RTL

- Parametrised writeback instruction tracking FIFO. Sits between ID/dispatch and WB.
- Records the destination register of every instruction that is dispatched but not yet written back.
- Detects RAW and WAW hazards against the instruction currently being dispatched and stalls dispatch through a ready/valid handshake.
- Adds the following over the previous tracker: configurable depth and register-address width, per-operand enables, x0 filtering, WAW check, an in-order tag returned at dispatch, an occupancy counter and a pipeline flush.

---
 rtl/witf_ptrk.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/witf_ptrk.sv
// -----------------------------------------------------------------------------
// witf_ptrk -- writeback instruction tracking FIFO
//
// Sits between ID/dispatch and WB. Every dispatched instruction allocates an
// entry holding its destination register; the entry is released in order when
// the head instruction completes writeback. Pending destinations are compared
// against the instruction being dispatched to detect RAW and WAW hazards, and
// dispatch is stalled through disp_ready.
//
// Handshake: an instruction is accepted on a rising clk edge where
// disp_valid & disp_ready are both 1. disp_ready is combinational and never
// depends on disp_valid except through the hazard terms, which are 0 when
// disp_valid is 0. A pop happens on an edge where wb_en & !empty.
//
// Parameters:
//   DEPTH  number of tracked entries (>= 1, any value)
//   AW     register index width
//   TW     tag / pointer width (derived)
//   CW     occupancy counter width (derived)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   disp_valid               ID presents an instruction
//   disp_rs1en/disp_rs1      rs1 read enable / index
//   disp_rs2en/disp_rs2      rs2 read enable / index
//   disp_rdwen/disp_rd       rd write enable / index
//   disp_ready               entry may be allocated this cycle
//   disp_itag                tag assigned on accept (write pointer)
//   raw_hazard, waw_hazard   hazard against pending destinations
//   wb_en                    head instruction completes writeback (pop)
//   wb_itag, wb_rd, wb_rdwen head tag and payload
//   flush                    discard all entries (priority over accept/pop)
//   full, empty, count       occupancy status
//
// Build option: define WITF_WB_BYPASS_EN to exclude the entry popping this
// cycle from the hazard match (regfile must forward the WB data).
// -----------------------------------------------------------------------------
module witf_ptrk #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 5,
    localparam int TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_valid,
    input  logic          disp_rs1en,
    input  logic [AW-1:0] disp_rs1,
    input  logic          disp_rs2en,
    input  logic [AW-1:0] disp_rs2,
    input  logic          disp_rdwen,
    input  logic [AW-1:0] disp_rd,
    output logic          disp_ready,
    output logic [TW-1:0] disp_itag,
    output logic          raw_hazard,
    output logic          waw_hazard,
    input  logic          wb_en,
    output logic [TW-1:0] wb_itag,
    output logic [AW-1:0] wb_rd,
    output logic          wb_rdwen,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [TW-1:0] LAST = TW'(DEPTH - 1);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_rdwen;
    logic [AW-1:0]    r_rd [DEPTH];
    logic [TW-1:0]    r_wptr;
    logic [TW-1:0]    r_rptr;
    logic             r_wflg;
    logic             r_rflg;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic             w_accept;
    logic             w_raw;
    logic             w_waw;
    logic             w_excl;
    logic             w_match;

    // Pointers wrap explicitly so non-power-of-two depths work; the flags
    // distinguish full from empty when the pointers are equal.
    function automatic logic [TW-1:0] ptr_next(input logic [TW-1:0] p);
        return (p == LAST) ? '0 : p + TW'(1);
    endfunction

    assign empty = (r_wptr == r_rptr) & (r_wflg == r_rflg);
    assign full  = (r_wptr == r_rptr) & (r_wflg != r_rflg);
    assign count = r_count;

    assign w_pop    = wb_en & ~empty;
    assign w_accept = disp_valid & disp_ready;

    // Hazard match against entries valid at the start of the cycle.
    always_comb begin
        w_raw   = 1'b0;
        w_waw   = 1'b0;
        w_excl  = 1'b0;
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef WITF_WB_BYPASS_EN
            // The head entry writing back this cycle no longer blocks dispatch.
            w_excl = w_pop & (r_rptr == TW'(i));
`else
            w_excl = 1'b0;
`endif
            // x0 is never a real dependency.
            w_match = r_vld[i] & r_rdwen[i] & (r_rd[i] != '0) & ~w_excl;
            if (w_match) begin
                if ((disp_rs1en && r_rd[i] == disp_rs1) ||
                    (disp_rs2en && r_rd[i] == disp_rs2))
                    w_raw = 1'b1;
                if (disp_rdwen && r_rd[i] == disp_rd)
                    w_waw = 1'b1;
            end
        end
    end

    assign raw_hazard = disp_valid & w_raw;
    assign waw_hazard = disp_valid & w_waw;
    assign disp_ready = ~full & ~raw_hazard & ~waw_hazard & ~flush;

    assign disp_itag = r_wptr;
    assign wb_itag   = r_rptr;
    assign wb_rd     = r_rd[r_rptr];
    assign wb_rdwen  = r_rdwen[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_rdwen <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_rd[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_wflg  <= 1'b0;
            r_rflg  <= 1'b0;
            r_count <= '0;
        end else if (flush) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_wflg  <= 1'b0;
            r_rflg  <= 1'b0;
            r_count <= '0;
        end else begin
            // Accept and pop never target the same slot: equal pointers mean
            // either empty (no pop) or full (no accept).
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= ptr_next(r_rptr);
                if (r_rptr == LAST)
                    r_rflg <= ~r_rflg;
            end
            if (w_accept) begin
                r_vld[r_wptr]   <= 1'b1;
                r_rdwen[r_wptr] <= disp_rdwen;
                r_rd[r_wptr]    <= disp_rd;
                r_wptr          <= ptr_next(r_wptr);
                if (r_wptr == LAST)
                    r_wflg <= ~r_wflg;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
